// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package mult_div_pkg;
    localparam int   DEF_WIDTH = 32;
    localparam logic OP_DIV    = 1'b0;
    localparam logic OP_MULT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // Partial remainder stays below the divisor, so the shifted value never needs more than WIDTH+1 bits.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_ge      = (w_shifted >= {2'b00, i_divisor});
    assign w_diff    = w_shifted[WIDTH:0] - {1'b0, i_divisor};
    assign o_rem     = w_ge ? w_diff : w_shifted[WIDTH:0];
    assign o_quo     = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) engine.
// One operation takes WIDTH iterations; results land on HighOut/LowOut on entry to FIN.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HighOut,
    output logic [WIDTH-1:0] LowOut
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_m;
    logic             r_qm1;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_divzero;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_low;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_b_zero;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_booth_acc;
    logic [WIDTH-1:0] w_booth_mq;
    logic [WIDTH:0]   w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic             w_last;

    assign w_abs_a  = A[WIDTH-1] ? -A : A;
    assign w_abs_b  = B[WIDTH-1] ? -B : B;
    assign w_b_zero = (B == '0);
    assign w_last   = (r_cnt == '0);

    // Booth: accumulator carries one guard bit so -2^(W-1) operands cannot overflow.
    assign w_m_ext = {r_m[WIDTH-1], r_m};

    always_comb begin
        w_booth_sum = r_acc;
        case ({r_mq[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
    end

    assign w_booth_acc = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
    assign w_booth_mq  = {w_booth_sum[0], r_mq[WIDTH-1:1]};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc),
        .i_quo     (r_mq),
        .i_divisor (r_m),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_rem_mag = w_div_rem[WIDTH-1:0];
    assign w_rem_fix = r_neg_r ? -w_rem_mag : w_rem_mag;
    assign w_quo_fix = r_neg_q ? -w_div_quo : w_div_quo;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (Op == OP_MULT)  w_state_nxt = MULT;
                    else if (!w_b_zero) w_state_nxt = DIV;
                    else                w_state_nxt = FIN;
                end
            end
            MULT:    if (w_last) w_state_nxt = FIN;
            DIV:     if (w_last) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divzero <= 1'b0;
            r_high    <= '0;
            r_low     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_acc     <= '0;
                        r_qm1     <= 1'b0;
                        r_neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_neg_r   <= A[WIDTH-1];
                        r_divzero <= (Op == OP_DIV) && w_b_zero;
                        if (Op == OP_MULT) begin
                            r_m  <= A;
                            r_mq <= B;
                        end else begin
                            r_m  <= w_abs_b;
                            r_mq <= w_abs_a;
                        end
                    end
                end
                MULT: begin
                    r_acc <= w_booth_acc;
                    r_mq  <= w_booth_mq;
                    r_qm1 <= r_mq[0];
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_high <= w_booth_acc[WIDTH-1:0];
                        r_low  <= w_booth_mq;
                    end
                end
                DIV: begin
                    r_acc <= w_div_rem;
                    r_mq  <= w_div_quo;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Sign fix-up happens on the way into FIN so results are valid during Done.
                    if (w_last) begin
                        r_high <= w_rem_fix;
                        r_low  <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (r_state != IDLE);
    assign Done    = (r_state == FIN);
    assign DivZero = r_divzero;
    assign HighOut = r_high;
    assign LowOut  = r_low;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random checks of mult_div_unit against a plain-arithmetic signed reference.
module tb_mult_div_unit;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] HighOut;
    logic [31:0] LowOut;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .HighOut (HighOut),
        .LowOut  (LowOut)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p;
    endfunction

    // Quotient truncates toward zero, remainder follows the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_expect(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_dz = (op == 1'b0) && (b == 32'd0);
        if (!exp_dz) begin
            r      = op ? ref_mult(a, b) : ref_div(a, b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
        end
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!Done && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    // Runs one op from IDLE; optional Start pulse while busy must be ignored.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse_mid);
        int n;
        set_expect(op, a, b);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0; A = $urandom; B = $urandom; Op = ~op;
        n = 1;
        while (!Done && n < 100) begin
            Start = (pulse_mid && n == 5);
            @(posedge Clk); #1;
            n++;
        end
        Start = 1'b0;
        chk({tag, "_done"}, 64'(Done), 64'(1));
        chk({tag, "_latency"}, 64'(n), exp_dz ? 64'(1) : 64'(33));
        chk({tag, "_busy_fin"}, 64'(Busy), 64'(1));
        chk({tag, "_hi"}, 64'(HighOut), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(LowOut), 64'(exp_lo));
        chk({tag, "_divzero"}, 64'(DivZero), 64'(exp_dz));
        @(posedge Clk); #1;
        chk({tag, "_done_fall"}, 64'(Done), 64'(0));
        chk({tag, "_busy_idle"}, 64'(Busy), 64'(0));
    endtask

    initial begin
        int n;
        int done_cnt;
        logic [31:0] ra, rb;
        logic        rop;

        Reset = 1'b1; Start = 1'b0; Op = 1'b0; A = '0; B = '0;
        #12;
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_divzero", 64'(DivZero), 64'(0));
        chk("rst_hi", 64'(HighOut), 64'(0));
        chk("rst_lo", 64'(LowOut), 64'(0));
        Reset = 1'b0;
        @(posedge Clk); #1;

        run_op("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
        chk("mul_7x-3_hi_const", 64'(HighOut), 64'h0000_0000_FFFF_FFFF);
        chk("mul_7x-3_lo_const", 64'(LowOut), 64'h0000_0000_FFFF_FFEB);
        run_op("mul_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mul_min_sq_hi_const", 64'(HighOut), 64'h0000_0000_4000_0000);
        run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_-7/2_lo_const", 64'(LowOut), 64'h0000_0000_FFFF_FFFD);
        run_op("div_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_min/-1_lo_const", 64'(LowOut), 64'h0000_0000_8000_0000);
        run_op("div_5/0", 1'b0, 32'd5, 32'd0, 1'b0);
        chk("div_5/0_hold_lo", 64'(LowOut), 64'h0000_0000_8000_0000);
        run_op("div_after_dz", 1'b0, 32'd100, 32'hFFFF_FFF9, 1'b0);
        run_op("mul_pulse_busy", 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
        run_op("div_pulse_busy", 1'b0, 32'h7FFF_FFFF, 32'd3, 1'b1);

        // Reset in the middle of a multiply
        Start = 1'b1; Op = 1'b1; A = 32'd12345; B = 32'd678;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (10) begin @(posedge Clk); #1; end
        Reset = 1'b1; #1;
        chk("midrst_busy", 64'(Busy), 64'(0));
        chk("midrst_done", 64'(Done), 64'(0));
        chk("midrst_hi", 64'(HighOut), 64'(0));
        chk("midrst_lo", 64'(LowOut), 64'(0));
        @(posedge Clk); #1;
        Reset = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done) done_cnt++;
        end
        chk("midrst_no_done", 64'(done_cnt), 64'(0));
        run_op("mul_after_rst", 1'b1, 32'hFFFF_FF00, 32'd1000, 1'b0);

        // Start held high: two back-to-back operations
        set_expect(1'b1, 32'hCAFE_0001, 32'h0000_0F0F);
        Start = 1'b1; Op = 1'b1; A = 32'hCAFE_0001; B = 32'h0000_0F0F;
        @(posedge Clk); #1;
        Op = 1'b0; A = 32'hFFFF_0000; B = 32'd77;
        wait_done(n);
        chk("b2b1_latency", 64'(n), 64'(33));
        chk("b2b1_hi", 64'(HighOut), 64'(exp_hi));
        chk("b2b1_lo", 64'(LowOut), 64'(exp_lo));
        @(posedge Clk); #1;
        chk("b2b_idle_busy", 64'(Busy), 64'(0));
        chk("b2b_idle_done", 64'(Done), 64'(0));
        @(posedge Clk); #1;
        chk("b2b2_accept_busy", 64'(Busy), 64'(1));
        Start = 1'b0;
        set_expect(1'b0, 32'hFFFF_0000, 32'd77);
        wait_done(n);
        chk("b2b2_latency", 64'(n), 64'(33));
        chk("b2b2_hi", 64'(HighOut), 64'(exp_hi));
        chk("b2b2_lo", 64'(LowOut), 64'(exp_lo));
        chk("b2b2_divzero", 64'(DivZero), 64'(0));
        @(posedge Clk); #1;

        for (int i = 0; i < 14; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = {{28{rb[31]}}, rb[3:0]};
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
